// File: rtl/hvsync_pkg.sv
// Shared video timing defaults and the beam-position type used by every pixel generator.
package hvsync_pkg;

  localparam int POS_W = 9;
  typedef logic [POS_W-1:0] pos_t;

  localparam int H_DISPLAY = 256;
  localparam int H_BACK    = 23;
  localparam int H_FRONT   = 7;
  localparam int H_SYNC    = 23;
  localparam int V_DISPLAY = 240;
  localparam int V_TOP     = 5;
  localparam int V_BOTTOM  = 14;
  localparam int V_SYNC    = 3;

endpackage

// File: rtl/hvsync_counter.sv
// Wrap counter for one raster axis: advances when enabled, returns to 0 after MAX.
module hvsync_counter
  import hvsync_pkg::*;
#(
  parameter pos_t MAX = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output pos_t count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (en) begin
      count <= (count == MAX) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/hvsync_generator.sv
// Free-running raster timing: beam position, registered syncs and display-active flag.
// Optional HVSYNC_FRAME_PULSE_EN adds a one-clock frame_start output at (0,0).
module hvsync_generator #(
  parameter int H_DISPLAY = hvsync_pkg::H_DISPLAY,
  parameter int H_BACK    = hvsync_pkg::H_BACK,
  parameter int H_FRONT   = hvsync_pkg::H_FRONT,
  parameter int H_SYNC    = hvsync_pkg::H_SYNC,
  parameter int V_DISPLAY = hvsync_pkg::V_DISPLAY,
  parameter int V_TOP     = hvsync_pkg::V_TOP,
  parameter int V_BOTTOM  = hvsync_pkg::V_BOTTOM,
  parameter int V_SYNC    = hvsync_pkg::V_SYNC
) (
  input  logic              clk,
  input  logic              reset,
  output logic              hsync,
  output logic              vsync,
  output logic              display_on,
  output hvsync_pkg::pos_t  hpos,
  output hvsync_pkg::pos_t  vpos
`ifdef HVSYNC_FRAME_PULSE_EN
  ,
  output logic              frame_start
`endif
);
  import hvsync_pkg::*;

  localparam pos_t H_MAX        = pos_t'(H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1);
  localparam pos_t H_SYNC_START = pos_t'(H_DISPLAY + H_FRONT);
  localparam pos_t H_SYNC_END   = pos_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam pos_t H_VIS        = pos_t'(H_DISPLAY);
  localparam pos_t V_MAX        = pos_t'(V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1);
  localparam pos_t V_SYNC_START = pos_t'(V_DISPLAY + V_BOTTOM);
  localparam pos_t V_SYNC_END   = pos_t'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);
  localparam pos_t V_VIS        = pos_t'(V_DISPLAY);

  logic line_end;

  assign line_end = (hpos == H_MAX);

  hvsync_counter #(.MAX(H_MAX)) u_hcount (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .count (hpos)
  );

  // Vertical position only moves on the clock that wraps the line.
  hvsync_counter #(.MAX(V_MAX)) u_vcount (
    .clk   (clk),
    .reset (reset),
    .en    (line_end),
    .count (vpos)
  );

  // Syncs sample the pre-edge position, so they trail hpos/vpos by one clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hsync <= 1'b0;
      vsync <= 1'b0;
    end else begin
      hsync <= (hpos >= H_SYNC_START) && (hpos <= H_SYNC_END);
      vsync <= (vpos >= V_SYNC_START) && (vpos <= V_SYNC_END);
    end
  end

  assign display_on = (hpos < H_VIS) && (vpos < V_VIS);

`ifdef HVSYNC_FRAME_PULSE_EN
  // Armed by reset so the first pixel after release is flagged; gated so it reads 0 in reset.
  logic frame_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_q <= 1'b1;
    end else begin
      frame_q <= line_end && (vpos == V_MAX);
    end
  end

  assign frame_start = frame_q && reset;
`endif

endmodule

// File: tb/tb_hvsync_generator.sv
// Self-checking bench for hvsync_generator: per-clock scoreboard against a raster model plus targeted checks.
module tb_hvsync_generator;
  import hvsync_pkg::*;

  localparam int W          = 21;
  localparam int LINE       = H_DISPLAY + H_BACK + H_FRONT + H_SYNC;
  localparam int LINES      = V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC;
  localparam int FRAME      = LINE * LINES;
  localparam int HS_FIRST   = H_DISPLAY + H_FRONT;
  localparam int HS_LAST    = HS_FIRST + H_SYNC - 1;
  localparam int VS_FIRST   = V_DISPLAY + V_BOTTOM;
  localparam int VS_LAST    = VS_FIRST + V_SYNC - 1;

  logic       clk;
  logic       reset;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic [8:0] hpos;
  logic [8:0] vpos;
`ifdef HVSYNC_FRAME_PULSE_EN
  logic       frame_start;
`endif

  int checks;
  int errors;
  logic [W-1:0] exp_q[$];

  int   m_h;
  int   m_v;
  logic m_hs;
  logic m_vs;

  hvsync_generator dut (
    .clk        (clk),
    .reset      (reset),
    .hsync      (hsync),
    .vsync      (vsync),
    .display_on (display_on),
    .hpos       (hpos),
    .vpos       (vpos)
`ifdef HVSYNC_FRAME_PULSE_EN
    ,
    .frame_start(frame_start)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_word();
    logic [8:0] h9;
    logic [8:0] v9;
    logic       disp;
    h9   = m_h[8:0];
    v9   = m_v[8:0];
    disp = (m_h < H_DISPLAY) && (m_v < V_DISPLAY);
    return {m_hs, m_vs, disp, h9, v9};
  endfunction

  function automatic logic [W-1:0] dut_word();
    return {hsync, vsync, display_on, hpos, vpos};
  endfunction

  task automatic model_reset();
    m_h  = 0;
    m_v  = 0;
    m_hs = 1'b0;
    m_vs = 1'b0;
    exp_q.delete();
  endtask

  // driver: one clock; the model advances on the same edge and pushes the expected outputs
  task automatic step();
    @(posedge clk);
    m_hs = (m_h >= HS_FIRST) && (m_h <= HS_LAST);
    m_vs = (m_v >= VS_FIRST) && (m_v <= VS_LAST);
    if (m_h == LINE - 1) begin
      m_h = 0;
      m_v = (m_v == LINES - 1) ? 0 : m_v + 1;
    end else begin
      m_h = m_h + 1;
    end
    exp_q.push_back(model_word());
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [W-1:0] got;
    logic [W-1:0] want;
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if (hpos !== 9'd0)       begin errors++; $display("FAIL reset_hpos got=%0d want=0", hpos); end
    checks++; if (vpos !== 9'd0)       begin errors++; $display("FAIL reset_vpos got=%0d want=0", vpos); end
    checks++; if (hsync !== 1'b0)      begin errors++; $display("FAIL reset_hsync got=%b want=0", hsync); end
    checks++; if (vsync !== 1'b0)      begin errors++; $display("FAIL reset_vsync got=%b want=0", vsync); end
    checks++; if (display_on !== 1'b1) begin errors++; $display("FAIL reset_display_on got=%b want=1", display_on); end
`ifdef HVSYNC_FRAME_PULSE_EN
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start got=%b want=0", frame_start); end
`endif
    reset = 1'b1;
`ifdef HVSYNC_FRAME_PULSE_EN
    #1;
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL release_frame_start got=%b want=1", frame_start); end
`endif
    step();
    got  = dut_word();
    want = exp_q.pop_front();
    checks++; if (got !== want) begin errors++; $display("FAIL sb_release got=%h want=%h", got, want); end
    checks++; if (hpos !== 9'd1) begin errors++; $display("FAIL release_hpos got=%0d want=1", hpos); end
  endtask

  task automatic test_line_wrap();
    logic [W-1:0] got;
    logic [W-1:0] want;
    int   hs_w;
    int   hs_rise;
    int   hs_fall;
    int   disp_fall;
    logic prev_hs;
    logic prev_disp;
    hs_w      = 0;
    hs_rise   = -1;
    hs_fall   = -1;
    disp_fall = -1;
    prev_hs   = hsync;
    prev_disp = display_on;
    repeat (LINE - 1) begin
      step();
      got  = dut_word();
      want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL sb_line h=%0d v=%0d got=%h want=%h", m_h, m_v, got, want); end
      if (hsync && !prev_hs && hs_rise < 0) hs_rise = int'(hpos);
      if (!hsync && prev_hs && hs_fall < 0) hs_fall = int'(hpos);
      if (!display_on && prev_disp && disp_fall < 0) disp_fall = int'(hpos);
      if (hsync) hs_w++;
      prev_hs   = hsync;
      prev_disp = display_on;
    end
    checks++; if (hpos !== 9'd0)       begin errors++; $display("FAIL line_wrap_hpos got=%0d want=0", hpos); end
    checks++; if (vpos !== 9'd1)       begin errors++; $display("FAIL line_wrap_vpos got=%0d want=1", vpos); end
    checks++; if (display_on !== 1'b1) begin errors++; $display("FAIL line_disp_rise got=%b want=1", display_on); end
    checks++; if (disp_fall !== H_DISPLAY) begin errors++; $display("FAIL line_disp_fall got=%0d want=%0d", disp_fall, H_DISPLAY); end
    checks++; if (hs_rise !== HS_FIRST + 1) begin errors++; $display("FAIL hsync_rise got=%0d want=%0d", hs_rise, HS_FIRST + 1); end
    checks++; if (hs_fall !== HS_LAST + 2)  begin errors++; $display("FAIL hsync_fall got=%0d want=%0d", hs_fall, HS_LAST + 2); end
    checks++; if (hs_w !== H_SYNC) begin errors++; $display("FAIL hsync_width got=%0d want=%0d", hs_w, H_SYNC); end
  endtask

  task automatic test_frame_wrap();
    logic [W-1:0] got;
    logic [W-1:0] want;
    int   vs_w;
    int   vs_rise_v;
    int   vs_rise_h;
    int   hs_rises;
    int   disp_bad;
    logic prev_hs;
    logic prev_vs;
    vs_w      = 0;
    vs_rise_v = -1;
    vs_rise_h = -1;
    hs_rises  = 0;
    disp_bad  = 0;
    prev_hs   = hsync;
    prev_vs   = vsync;
    repeat (FRAME - LINE) begin
      step();
      got  = dut_word();
      want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL sb_frame h=%0d v=%0d got=%h want=%h", m_h, m_v, got, want); end
      if (vsync && !prev_vs && vs_rise_v < 0) begin
        vs_rise_v = int'(vpos);
        vs_rise_h = int'(hpos);
      end
      if (hsync && !prev_hs) hs_rises++;
      if (vsync) vs_w++;
      if (display_on && vpos >= 9'(V_DISPLAY)) disp_bad++;
      prev_hs = hsync;
      prev_vs = vsync;
    end
    checks++; if (hpos !== 9'd0) begin errors++; $display("FAIL frame_wrap_hpos got=%0d want=0", hpos); end
    checks++; if (vpos !== 9'd0) begin errors++; $display("FAIL frame_wrap_vpos got=%0d want=0", vpos); end
    checks++; if (vs_w !== V_SYNC * LINE) begin errors++; $display("FAIL vsync_width got=%0d want=%0d", vs_w, V_SYNC * LINE); end
    checks++; if (vs_rise_v !== VS_FIRST) begin errors++; $display("FAIL vsync_rise_v got=%0d want=%0d", vs_rise_v, VS_FIRST); end
    checks++; if (vs_rise_h !== 1) begin errors++; $display("FAIL vsync_rise_h got=%0d want=1", vs_rise_h); end
    checks++; if (hs_rises !== LINES - 1) begin errors++; $display("FAIL hsync_pulses got=%0d want=%0d", hs_rises, LINES - 1); end
    checks++; if (disp_bad !== 0) begin errors++; $display("FAIL disp_in_vblank got=%0d want=0", disp_bad); end
`ifdef HVSYNC_FRAME_PULSE_EN
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL frame_start_wrap got=%b want=1", frame_start); end
`endif
  endtask

  task automatic test_async_reset();
    logic [W-1:0] got;
    logic [W-1:0] want;
    int   budget;
    budget = 0;
    while (!(m_v == 5 && m_h == 270) && budget < 2000) begin
      step();
      got  = dut_word();
      want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL sb_pre_reset h=%0d v=%0d got=%h want=%h", m_h, m_v, got, want); end
      budget++;
    end
    checks++; if (budget >= 2000) begin errors++; $display("FAIL async_reach got=%0d want<2000", budget); end
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL pre_reset_hsync got=%b want=1", hsync); end
    #2 reset = 1'b0;
    #1;
    checks++; if (hpos !== 9'd0)       begin errors++; $display("FAIL async_hpos got=%0d want=0", hpos); end
    checks++; if (vpos !== 9'd0)       begin errors++; $display("FAIL async_vpos got=%0d want=0", vpos); end
    checks++; if (hsync !== 1'b0)      begin errors++; $display("FAIL async_hsync got=%b want=0", hsync); end
    checks++; if (vsync !== 1'b0)      begin errors++; $display("FAIL async_vsync got=%b want=0", vsync); end
    checks++; if (display_on !== 1'b1) begin errors++; $display("FAIL async_display_on got=%b want=1", display_on); end
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) begin
      step();
      got  = dut_word();
      want = exp_q.pop_front();
      checks++; if (got !== want) begin errors++; $display("FAIL sb_post_reset h=%0d v=%0d got=%h want=%h", m_h, m_v, got, want); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    test_reset();
    test_line_wrap();
    test_frame_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hvsync_generator.md
Name: hvsync_generator

Overview:
Free-running video timing generator producing horizontal/vertical sync, a display-active flag and the current beam position (hpos, vpos). Default timing is a 256x240 visible raster inside a 309x262 total frame, one pixel per clock. Sits at the root of every video pipeline; pixel generators (digit ROMs, sprite logic) derive their rendering from hpos/vpos/display_on.

Parameters:
H_DISPLAY, 256, visible pixels per line
H_BACK, 23, left border (back porch) pixels
H_FRONT, 7, right border (front porch) pixels
H_SYNC, 23, hsync pulse width in clocks
V_DISPLAY, 240, visible lines per frame
V_TOP, 5, top border lines
V_BOTTOM, 14, bottom border lines
V_SYNC, 3, vsync pulse width in lines

Ports:
clk  input  1  pixel clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
hsync  output  1  horizontal sync, active high, registered
vsync  output  1  vertical sync, active high, registered
display_on  output  1  high while beam is inside the visible area
hpos  output  9  current horizontal position, 0..H_MAX
vpos  output  9  current vertical position, 0..V_MAX

Behaviour:
- Derived constants: H_MAX = H_DISPLAY+H_BACK+H_FRONT+H_SYNC-1 (308); H_SYNC_START = H_DISPLAY+H_FRONT (263); H_SYNC_END = H_SYNC_START+H_SYNC-1 (285); V_MAX = V_DISPLAY+V_TOP+V_BOTTOM+V_SYNC-1 (261); V_SYNC_START = V_DISPLAY+V_BOTTOM (254); V_SYNC_END = V_SYNC_START+V_SYNC-1 (256).
- Reset (reset=0, asynchronous): hpos=0, vpos=0, hsync=0, vsync=0. Counting resumes on the first rising clk edge after reset deasserts.
- hpos: increments by 1 each clock; at H_MAX wraps to 0 on the next clock.
- vpos: increments by 1 on the clock where hpos wraps (hpos==H_MAX); if vpos==V_MAX at that moment, wraps to 0. vpos is otherwise stable for a full line.
- hsync: registered; next value = (H_SYNC_START <= hpos <= H_SYNC_END), sampling the pre-edge hpos, so hsync lags hpos by one clock. Pulse is exactly H_SYNC clocks wide per line.
- vsync: registered; next value = (V_SYNC_START <= vpos <= V_SYNC_END), same one-clock lag. Pulse is exactly V_SYNC lines wide.
- display_on: combinational = (hpos < H_DISPLAY) && (vpos < V_DISPLAY); zero latency relative to hpos/vpos.
- Frame period: (H_MAX+1)*(V_MAX+1) = 80958 clocks; line period 309 clocks.
- Reset asserted mid-frame: counters and syncs clear immediately, no partial-line completion.
- Parameter values must keep H_MAX and V_MAX at or below 511 (9-bit counters); out-of-range configuration is unsupported.

Optional Feature:
- Macro HVSYNC_FRAME_PULSE_EN. When defined: extra output frame_start (1 bit, registered), high for exactly one clock on the cycle where hpos==0 and vpos==0 (first pixel of every frame, including the first cycle after reset release); 0 during reset. When undefined: port absent, no extra logic; all other behaviour identical.

Decomposition:
- Shared package hvsync_pkg: default timing constants (H_DISPLAY…V_SYNC) and a position typedef (9-bit unsigned) reused by pixel generators.
- Derived constants computed as localparams inside the module.
- One natural sub-module: hvsync_counter (parameterised wrap counter with enable, used for both hpos and vpos); everything else stays in the top.

Test Plan:
- Reset: hold reset=0 several clocks -> hpos=0, vpos=0, hsync=0, vsync=0, display_on=1; release -> hpos=1 after first edge.
- Line wrap: run 309 clocks from reset -> hpos returns to 0, vpos=1; display_on falls at hpos=256 and rises at hpos=0.
- hsync timing: measure line -> hsync rises one clock after hpos=263, falls one clock after hpos=285, width 23 clocks, one pulse per 309 clocks.
- Frame wrap and vsync: run 80958 clocks -> vpos/hpos both 0 again; vsync high for 3 lines starting when vpos=254 (one-clock lag), display_on low for all of vpos 240..261.
- Async reset mid-frame: assert reset=0 at vpos=100, hpos=150 between clock edges -> outputs clear without waiting for a clock edge.
- With HVSYNC_FRAME_PULSE_EN: frame_start pulses once per 80958 clocks, single-cycle, aligned to hpos=0,vpos=0; absent when macro undefined.
